conv_back_grad_acc: RTL and testbench

//  Downstream of the CONV_BACK backprop MAC. Collects one gradient word per conv_sig pulse into a DEPTH-entry
//  per-kernel-tap accumulator, summing PASSES full sweeps of the taps. It then drains one scaled weight delta
//  per tap, -(acc >>> LR_SHIFT) saturated to DATA_W, over a valid/ready stream to the weight-update memory.

---
 rtl/conv_back_grad_acc_if.sv | 27 ++
 rtl/conv_back_grad_acc.sv | 148 ++++++++++++++
 tb/tb_conv_back_grad_acc.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_back_grad_acc_if.sv
// Purpose: bundles the gradient input stream and the weight-delta output stream of conv_back_grad_acc.
// Latency: none (wires only).
// Backpressure: out_ready throttles the delta stream; the gradient side has no ready and is qualified by grad_vld only.
// Ports: grad_in/grad_vld (to accumulator), out_valid/out_ready/out_idx/delta_out (delta stream).
interface conv_back_grad_acc_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
);
    logic signed [DATA_W-1:0] grad_in;
    logic                     grad_vld;
    logic                     out_valid;
    logic                     out_ready;
    logic [IDX_W-1:0]         out_idx;
    logic signed [DATA_W-1:0] delta_out;

    // master: the environment feeding gradients and consuming deltas
    modport master (
        output grad_in, grad_vld, out_ready,
        input  out_valid, out_idx, delta_out
    );

    // slave: the accumulator itself
    modport slave (
        input  grad_in, grad_vld, out_ready,
        output out_valid, out_idx, delta_out
    );
endinterface

// File: rtl/conv_back_grad_acc.sv
// Purpose: sums PASSES sweeps of DEPTH gradient words per kernel tap, then drains -(acc >>> LR_SHIFT) per tap.
// Latency: first delta is valid the cycle after the final gradient; drain runs at 1 tap/cycle.
// Backpressure: out_ready=0 holds out_idx/delta_out; gradients arriving outside ACCUM are dropped and flag err.
// Ports: clk, rst_n (sync, active low), clear (sync restart), bus (grad in / delta out stream),
//        busy (DRAIN or DONE), done (one-cycle pulse after last delta), err (sticky misuse flag).
module conv_back_grad_acc #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 24,
    parameter int DEPTH    = 9,
    parameter int PASSES   = 2,
    parameter int LR_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    conv_back_grad_acc_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PASS_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(PASSES - 1);

    // Clamp bounds: accumulator range, and the delta range expressed at ACC_W+1 bits
    localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] A_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   D_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   D_MIN = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic [PASS_W-1:0]       pass_q, pass_d;
    logic                    err_q, err_d;
    logic signed [ACC_W-1:0] acc_q [DEPTH];

    logic                    acc_we;
    logic [IDX_W-1:0]        acc_waddr;
    logic signed [ACC_W-1:0] acc_wdat;

    logic signed [ACC_W:0]    sum_w;
    logic signed [ACC_W-1:0]  sum_sat;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [ACC_W:0]    neg_w;
    logic signed [DATA_W-1:0] delta_sat;

    // Saturating accumulate: one guard bit catches overflow of the tap sum
    always_comb begin
        sum_w = $signed({acc_q[wr_idx_q][ACC_W-1], acc_q[wr_idx_q]})
              + $signed((ACC_W+1)'(bus.grad_in));
        if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
            sum_sat = sum_w[ACC_W] ? A_MIN : A_MAX;
        end else begin
            sum_sat = sum_w[ACC_W-1:0];
        end
    end

    // Delta: arithmetic shift floors toward -inf, negation widened so -A_MIN fits before clamping
    always_comb begin
        shifted = acc_q[rd_idx_q] >>> LR_SHIFT;
        neg_w   = -$signed({shifted[ACC_W-1], shifted});
        if (neg_w > D_MAX) begin
            delta_sat = D_MAX[DATA_W-1:0];
        end else if (neg_w < D_MIN) begin
            delta_sat = D_MIN[DATA_W-1:0];
        end else begin
            delta_sat = neg_w[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        pass_d    = pass_q;
        err_d     = err_q;
        acc_we    = 1'b0;
        acc_waddr = wr_idx_q;
        acc_wdat  = sum_sat;
        unique case (state_q)
            S_ACCUM: begin
                if (bus.grad_vld) begin
                    acc_we = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        if (pass_q == LAST_PASS) begin
                            pass_d  = '0;
                            state_d = S_DRAIN;
                        end else begin
                            pass_d = pass_q + 1'b1;
                        end
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.grad_vld) err_d = 1'b1;
                if (bus.out_ready) begin
                    // Zero the tap as it leaves so the next round starts clean
                    acc_we    = 1'b1;
                    acc_waddr = rd_idx_q;
                    acc_wdat  = '0;
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = S_DONE;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.grad_vld) err_d = 1'b1;
                state_d = S_ACCUM;
            end
            default: state_d = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state_q  <= S_ACCUM;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            pass_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) acc_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            if (acc_we) acc_q[acc_waddr] <= acc_wdat;
        end
    end

    assign bus.out_valid = (state_q == S_DRAIN);
    assign bus.out_idx   = (state_q == S_DRAIN) ? rd_idx_q : '0;
    assign bus.delta_out = (state_q == S_DRAIN) ? delta_sat : '0;
    assign busy          = (state_q != S_ACCUM);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
endmodule

// File: tb/tb_conv_back_grad_acc.sv
// Purpose: exercises two accumulator instances (LR_SHIFT 4 and 0) from one shared stimulus stream.
// Latency: outputs sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Backpressure: out_ready is driven directly, including held-low stalls and random throttling.
module tb_conv_back_grad_acc;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 24;
    localparam int DEPTH  = 9;
    localparam int PASSES = 2;
    localparam int IDX_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic grad_vld = 1'b0;
    logic out_ready = 1'b0;
    logic signed [DATA_W-1:0] grad_in = '0;
    logic busy_a, done_a, err_a, busy_b, done_b, err_b;

    int n_chk = 0;
    int n_fail = 0;

    conv_back_grad_acc_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) ifa ();
    conv_back_grad_acc_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) ifb ();

    assign ifa.grad_in   = grad_in;
    assign ifa.grad_vld  = grad_vld;
    assign ifa.out_ready = out_ready;
    assign ifb.grad_in   = grad_in;
    assign ifb.grad_vld  = grad_vld;
    assign ifb.out_ready = out_ready;

    conv_back_grad_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .PASSES(PASSES), .LR_SHIFT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifa),
        .busy(busy_a), .done(done_a), .err(err_a)
    );
    conv_back_grad_acc #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .PASSES(PASSES), .LR_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(ifb),
        .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase 0 = collecting gradients, 1 = handing out deltas, 2 = the single done cycle
    int m_acc [2][DEPTH];
    int m_phase = 0;
    int m_ngrad = 0;
    int m_rd = 0;
    bit m_err = 1'b0;
    int m_g;

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int shift_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic int exp_delta(input int k, input int tap);
        int fl;
        fl = m_acc[k][tap] >>> shift_of(k);
        return clamp(-fl, -32768, 32767);
    endfunction

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++) m_acc[k][i] = 0;
    end

    always @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < DEPTH; i++) m_acc[k][i] = 0;
            m_phase = 0; m_ngrad = 0; m_rd = 0; m_err = 1'b0;
        end else if (m_phase == 0) begin
            if (grad_vld) begin
                m_g = grad_in;
                for (int k = 0; k < 2; k++)
                    m_acc[k][m_ngrad % DEPTH] = clamp(m_acc[k][m_ngrad % DEPTH] + m_g,
                                                      -(1 << (ACC_W-1)), (1 << (ACC_W-1)) - 1);
                m_ngrad++;
                if (m_ngrad == DEPTH * PASSES) begin
                    m_ngrad = 0; m_phase = 1; m_rd = 0;
                end
            end
        end else if (m_phase == 1) begin
            if (grad_vld) m_err = 1'b1;
            if (out_ready) begin
                for (int k = 0; k < 2; k++) m_acc[k][m_rd] = 0;
                m_rd++;
                if (m_rd == DEPTH) begin
                    m_rd = 0; m_phase = 2;
                end
            end
        end else begin
            if (grad_vld) m_err = 1'b1;
            m_phase = 0;
        end
    end

    task automatic cmp_dut(input string tag, input int k, input logic v, input logic [IDX_W-1:0] idx,
                           input logic signed [DATA_W-1:0] d, input logic b, input logic dn, input logic e);
        chk({tag, "_valid"}, v, m_phase == 1);
        chk({tag, "_busy"}, b, m_phase != 0);
        chk({tag, "_done"}, dn, m_phase == 2);
        chk({tag, "_err"}, e, m_err);
        if (m_phase == 1) begin
            chk({tag, "_idx"}, idx, m_rd);
            chk({tag, "_delta"}, d, exp_delta(k, m_rd));
        end
    endtask

    // Compare process: every falling edge after the first rising edge
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cmp_dut("a", 0, ifa.out_valid, ifa.out_idx, ifa.delta_out, busy_a, done_a, err_a);
            cmp_dut("b", 1, ifb.out_valid, ifb.out_idx, ifb.delta_out, busy_b, done_b, err_b);
        end
    end

    // ---------------- observation of accepted deltas ----------------
    int qa_idx[$], qa_dat[$], qb_idx[$], qb_dat[$];
    int done_cnt = 0;
    int busy_cnt = 0;

    always @(negedge clk) begin
        if (ifa.out_valid && out_ready) begin
            qa_idx.push_back(int'(ifa.out_idx)); qa_dat.push_back(int'(ifa.delta_out));
        end
        if (ifb.out_valid && out_ready) begin
            qb_idx.push_back(int'(ifb.out_idx)); qb_dat.push_back(int'(ifb.delta_out));
        end
        if (done_a) done_cnt++;
        if (busy_a) busy_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        qa_idx.delete(); qa_dat.delete(); qb_idx.delete(); qb_dat.delete();
        done_cnt = 0; busy_cnt = 0;
    endtask

    task automatic feed(input int n, input int val, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            grad_vld = 1'b1;
            grad_in  = 16'(val);
            tick();
            grad_vld = 1'b0;
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int c;
        c = 0;
        while (done_cnt == 0 && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_done_seen"}, done_cnt > 0, 1);
        tick();
        tick();
    endtask

    task automatic check_drain(input string name, input int exp_a, input int exp_b);
        chk({name, "_count_a"}, qa_idx.size(), DEPTH);
        chk({name, "_count_b"}, qb_idx.size(), DEPTH);
        for (int i = 0; i < qa_idx.size() && i < DEPTH; i++) begin
            chk({name, "_idx_a"}, qa_idx[i], i);
            chk({name, "_delta_a"}, qa_dat[i], exp_a);
        end
        for (int i = 0; i < qb_idx.size() && i < DEPTH; i++) begin
            chk({name, "_idx_b"}, qb_idx[i], i);
            chk({name, "_delta_b"}, qb_dat[i], exp_b);
        end
    endtask

    initial begin
        // 1: reset held with grad_vld toggling
        rst_n = 1'b0; out_ready = 1'b0; grad_in = 16'sd100;
        for (int i = 0; i < 4; i++) begin
            grad_vld = (i % 2 == 0);
            tick();
        end
        @(negedge clk);
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_idx", ifa.out_idx, 0);
        chk("rst_delta", ifa.delta_out, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_err", err_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; grad_vld = 1'b0;

        // 2: basic sweep; valid the cycle after the last gradient
        clear_obs(); out_ready = 1'b1;
        feed(18, 16, 1'b0);
        chk("model_acc_tap0", m_acc[0][0], 32);
        @(negedge clk);
        chk("lat_valid", ifa.out_valid, 1);
        wait_done("basic", 40);
        chk("basic_busy_cycles", busy_cnt, 10);
        chk("basic_done_pulses", done_cnt, 1);
        check_drain("basic", -2, -32);

        // 3: stall at tap 3 for five cycles
        clear_obs(); out_ready = 1'b1;
        feed(18, 16, 1'b0);
        for (int c = 0; c < 30; c++) begin
            tick();
            if (qa_idx.size() >= 3) break;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_idx", ifa.out_idx, 3);
            chk("stall_delta", ifa.delta_out, -2);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("stall", 40);
        check_drain("stall", -2, -32);

        // 4: floor rounding and output saturation
        clear_obs();
        feed(18, -1, 1'b1);
        wait_done("round", 40);
        check_drain("round", 1, 2);
        clear_obs();
        feed(18, -32768, 1'b0);
        chk("model_acc_sat", m_acc[1][4], -65536);
        wait_done("sat", 40);
        check_drain("sat", 4096, 32767);

        // 5: gradient during DRAIN is dropped and flags err
        clear_obs(); out_ready = 1'b0;
        feed(18, 16, 1'b0);
        grad_vld = 1'b1; grad_in = 16'sd1000;
        tick();
        grad_vld = 1'b0;
        @(negedge clk);
        chk("misuse_err", err_a, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("misuse", 40);
        check_drain("misuse", -2, -32);
        chk("misuse_err_sticky", err_a, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clear_err", err_a, 0);
        @(posedge clk); #1;
        clear_obs();
        feed(18, 16, 1'b0);
        wait_done("post_clear", 40);
        check_drain("post_clear", -2, -32);

        // 6: clear mid-accumulation, then reset mid-drain
        clear_obs();
        feed(5, 16, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        feed(18, 32, 1'b0);
        wait_done("mid_clear", 40);
        check_drain("mid_clear", -4, -64);
        clear_obs();
        feed(18, 16, 1'b0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_drain_valid", ifa.out_valid, 0);
        chk("rst_drain_busy", busy_a, 0);
        @(posedge clk); #1;
        repeat (12) tick();
        chk("rst_drain_no_done", done_cnt, 0);
        clear_obs();
        feed(18, 16, 1'b0);
        wait_done("post_rst", 40);
        check_drain("post_rst", -2, -32);

        // Randomized traffic: gradients, throttling, rare clears; model checks every cycle
        for (int c = 0; c < 600; c++) begin
            grad_vld  = ($urandom_range(0, 2) != 0);
            grad_in   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 149) == 0);
            tick();
        end
        grad_vld = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
